// File: rtl/corr_pkg.sv
// Shared types and constants for the correlation sequencer.
package corr_pkg;

  localparam int TAPS           = 16;
  localparam int WORDS          = 4;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_WIN = 3'd1,
    S_LOAD_FLT = 3'd2,
    S_CLEAR    = 3'd3,
    S_ACCUM    = 3'd4,
    S_SETTLE   = 3'd5,
    S_OUT      = 3'd6
  } corr_state_t;

endpackage

// File: rtl/corr_sequencer.sv
// Control sequencer for the correlation datapath: loads window and filter
// words from memory into the datapath buffers, sweeps the MAC over all taps,
// then holds the captured MAC result on a valid/ready output.
//
// Handshakes:
//  - mem_req/mem_addr are held steady until a cycle with mem_ack=1; that
//    cycle is the transfer, and mem_rdata is valid in it.
//  - result_valid/result_data are held steady until a cycle with
//    result_valid && result_ready; that cycle is the transfer.
module corr_sequencer
  import corr_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int MAC_W  = 12,
  parameter int TAPS   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] win_base,
  input  logic [ADDR_W-1:0] flt_base,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  byte_t             mem_rdata [0:3],
  output byte_t             window_buff_in [0:3],
  output byte_t             filter_buff_in [0:3],
  output logic              write_window_buff_en,
  output logic              write_filter_buff_en,
  output logic [1:0]        write_window_buff_ind,
  output logic [1:0]        write_filter_buff_ind,
  output logic              reset_mac,
  output logic              partial_res_en,
  output logic [3:0]        read_four_to_four_buff_ind,
  input  logic [MAC_W-1:0]  mac_in,
  output logic [MAC_W-1:0]  result_data,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam logic [1:0] LAST_WORD = 2'(WORDS - 1);
  localparam logic [3:0] LAST_TAP  = 4'(TAPS - 1);

  corr_state_t       state_q, state_d;
  logic [1:0]        w_q, w_d;
  logic [3:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] win_base_q, win_base_d;
  logic [ADDR_W-1:0] flt_base_q, flt_base_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              reset_mac_q, reset_mac_d;
  logic              pres_en_q, pres_en_d;
  logic [MAC_W-1:0]  result_q, result_d;
  logic              valid_q, valid_d;

  // Next-state and next-output computation for the whole sequence.
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    idx_d       = idx_q;
    win_base_d  = win_base_q;
    flt_base_d  = flt_base_q;
    busy_d      = busy_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    reset_mac_d = 1'b0;
    pres_en_d   = pres_en_q;
    result_d    = result_q;
    valid_d     = valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          win_base_d = win_base;
          flt_base_d = flt_base;
          busy_d     = 1'b1;
          mem_req_d  = 1'b1;
          mem_addr_d = win_base;
          w_d        = 2'd0;
          state_d    = S_LOAD_WIN;
        end
      end
      S_LOAD_WIN: begin
        if (mem_ack) begin
          if (w_q == LAST_WORD) begin
            w_d        = 2'd0;
            mem_addr_d = flt_base_q;
            state_d    = S_LOAD_FLT;
          end else begin
            w_d        = w_q + 2'd1;
            mem_addr_d = win_base_q + ADDR_W'(w_q + 2'd1);
          end
        end
      end
      S_LOAD_FLT: begin
        if (mem_ack) begin
          if (w_q == LAST_WORD) begin
            w_d         = 2'd0;
            mem_req_d   = 1'b0;
            mem_addr_d  = '0;
            reset_mac_d = 1'b1;
            state_d     = S_CLEAR;
          end else begin
            w_d        = w_q + 2'd1;
            mem_addr_d = flt_base_q + ADDR_W'(w_q + 2'd1);
          end
        end
      end
      S_CLEAR: begin
        pres_en_d = 1'b1;
        idx_d     = 4'd0;
        state_d   = S_ACCUM;
      end
      S_ACCUM: begin
        if (idx_q == LAST_TAP) begin
          pres_en_d = 1'b0;
          idx_d     = 4'd0;
          state_d   = S_SETTLE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_SETTLE: begin
        // The MAC has absorbed the last product by now; capture it.
        result_d = mac_in;
        valid_d  = 1'b1;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (result_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      w_q         <= 2'd0;
      idx_q       <= 4'd0;
      win_base_q  <= '0;
      flt_base_q  <= '0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      reset_mac_q <= 1'b0;
      pres_en_q   <= 1'b0;
      result_q    <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      idx_q       <= idx_d;
      win_base_q  <= win_base_d;
      flt_base_q  <= flt_base_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      reset_mac_q <= reset_mac_d;
      pres_en_q   <= pres_en_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
    end
  end

  // Memory data goes straight to both buffers; only the enables select.
  assign window_buff_in = mem_rdata;
  assign filter_buff_in = mem_rdata;

  assign write_window_buff_en  = (state_q == S_LOAD_WIN) && mem_ack;
  assign write_filter_buff_en  = (state_q == S_LOAD_FLT) && mem_ack;
  assign write_window_buff_ind = w_q;
  assign write_filter_buff_ind = w_q;

  assign busy                       = busy_q;
  assign mem_req                    = mem_req_q;
  assign mem_addr                   = mem_addr_q;
  assign reset_mac                  = reset_mac_q;
  assign partial_res_en             = pres_en_q;
  assign read_four_to_four_buff_ind = idx_q;
  assign result_data                = result_q;
  assign result_valid               = valid_q;

endmodule
